lsu_dmem_if: RTL and testbench

- Load/store unit directly downstream of the execute-stage ALU.
- Takes the effective address computed by the ALU (base + offset, e.g. sp + 44) together with the funct3/store flag and the store data.
- Runs one data-memory transaction over a valid/ack bus, aligns and byte-enables stores, and extracts plus sign/zero-extends loads.
- Returns a single-cycle response carrying load data or an error flag.

---
 rtl/lsu_dmem_if.sv | 182 ++++++++++++++++++
 tb/tb_lsu_dmem_if.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_if.sv
// Load/store unit bus interface: takes one ALU-computed access, runs a single
// valid/ack data-memory transaction and returns a one-cycle response with
// extended load data or an error flag.

// Per-byte-lane store steering: lane enable and the data byte for this lane.
module lsu_st_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 0 byte, 1 half, else word
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LID = 2'(LANE);

  // select the replicated store byte and the enable for this lane
  always_comb begin
    be    = 1'b0;
    wbyte = wdata[7:0];
    case (size)
      2'd0: begin
        be    = (off == LID);
        wbyte = wdata[7:0];
      end
      2'd1: begin
        be    = (off[1] == LID[1]);
        wbyte = wdata[8*(LANE%2) +: 8];
      end
      default: begin
        be    = 1'b1;
        wbyte = wdata[8*LANE +: 8];
      end
    endcase
  end
endmodule

module lsu_dmem_if #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        bad_f3, misal, reject;
  logic [31:0] shifted, ld_ext;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wd;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lsu_st_lane #(.LANE(l)) u_lane (
      .size  (req_funct3[1:0]),
      .off   (req_addr[1:0]),
      .wdata (req_wdata),
      .be    (lane_be[l]),
      .wbyte (lane_wd[l])
    );
  end

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  // classify the incoming request: illegal width or misaligned never reaches the bus
  always_comb begin
    bad_f3 = req_we ? (req_funct3[2] | (&req_funct3[1:0]))
                    : ((&req_funct3[1:0]) | (req_funct3 == 3'b110));
    misal  = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
             ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    reject = bad_f3 | misal;
  end

  // extract and extend the addressed byte/halfword from the returned word
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: error wins over ack, timeout only when neither arrives
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = reject ? RESP : ACCESS;
      ACCESS:  if (mem_ack | mem_err | tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request capture, bus fields, timeout counter and response result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      tmo_cnt   <= 8'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          f3_q      <= req_funct3;
          off_q     <= req_addr[1:0];
          err_q     <= reject;
          rdata_q   <= 32'h0;
          tmo_cnt   <= 8'h0;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_be    <= req_we ? lane_be : 4'hF;
          mem_wdata <= req_we ? lane_wd : 32'h0;
        end
        ACCESS: begin
          if (mem_err) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else if (mem_ack) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : ld_ext;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'h1;
          end
        end
        RESP:    tmo_cnt <= 8'h0;
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;
endmodule

// File: tb/tb_lsu_dmem_if.sv
// Randomized scoreboard bench for lsu_dmem_if: a driver pushes expected bus
// cycles and responses, a bus responder checks mem_* and answers, and a
// monitor pops and checks each rsp_valid pulse.
module tb_lsu_dmem_if;
  localparam int T = 16;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_TMO = 3, M_RST = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack, mem_err;
  logic [31:0] mem_rdata;

  lsu_dmem_if #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int last_rsp = -100;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    int          mode;
  } bus_t;

  rsp_t rq[$];
  bus_t bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: RV32I load/store semantics from byte-level arithmetic
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic rej, output logic [3:0] be,
                                output logic [31:0] mwd, output logic [31:0] ld);
    int size, off;
    logic legal;
    logic [31:0] mask, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    rej   = !legal || (off % size != 0);
    be    = 4'h0;
    mwd   = 32'h0;
    if (we) begin
      if (!rej) for (int i = 0; i < size; i++) be[off+i] = 1'b1;
      for (int j = 0; j < 4; j++) mwd[8*j +: 8] = wd[8*(j % size) +: 8];
    end else begin
      be = 4'hF;
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
    v    = (rd >> (8*off)) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    ld = we ? 32'h0 : v;
  endfunction

  // driver: present a request, push expectations, return at the negedge after accept
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int k, input int mode, input bit b2b);
    logic rej;
    logic [3:0] be;
    logic [31:0] mwd, ld;
    rsp_t r;
    bus_t b;
    int n;
    model(we, f3, a, wd, rd, rej, be, mwd, ld);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready 0 for %0d cycles, expected 1", n);
      req_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_accept_gap", 32'(cyc + 1 - last_rsp), 32'd2);
    r.acc = cyc + 1;
    if (rej) begin
      r.rdata = 32'h0; r.err = 1'b1; r.lat = 0;
    end else begin
      b.we = we; b.addr = {a[31:2], 2'b00}; b.be = be; b.wdata = mwd;
      b.rdata = rd; b.k = k; b.mode = mode;
      bq.push_back(b);
      r.rdata = (mode == M_ACK) ? ld : 32'h0;
      r.err   = (mode != M_ACK);
      r.lat   = (mode == M_TMO) ? T : k;
    end
    if (mode != M_RST || rej) rq.push_back(r);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // bus responder: checks the presented bus cycle every ACCESS cycle and answers per plan
  initial begin
    bus_t b;
    int n;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0; mem_err = 1'b0;
      if (rst_n && mem_req) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_bus: mem_req 1 with no bus cycle expected (cycle %0d)", cyc);
        end else begin
          b = bq.pop_front();
          n = 0;
          while (mem_req && n < 4*T) begin
            chk("mem_addr",  mem_addr, b.addr);
            chk("mem_be",    32'(mem_be), 32'(b.be));
            chk("mem_wdata", mem_wdata, b.wdata);
            chk("mem_we",    32'(mem_we), 32'(b.we));
            n++;
            if (b.mode <= M_BOTH && n == b.k) begin
              mem_rdata = b.rdata;
              mem_ack   = (b.mode != M_ERR);
              mem_err   = (b.mode != M_ACK);
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
          end
          if (b.mode != M_RST) chk("mem_req_cycles", 32'(n), 32'((b.mode == M_TMO) ? T : b.k));
        end
      end else begin
        // stray strobes while no access is in flight must be ignored
        mem_rdata = $urandom;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_err   = ($urandom_range(0, 5) == 0);
      end
    end
  end

  // response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: rsp_valid 1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          r = rq.pop_front();
          chk("rsp_rdata",   rsp_rdata, r.rdata);
          chk("rsp_err",     32'(rsp_err), 32'(r.err));
          chk("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
        end
        last_rsp = cyc;
      end else if (rst_n) begin
        chk("rsp_idle_zero", rsp_rdata | {31'h0, rsp_err}, 32'h0);
      end
    end
  end

  initial begin
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    int t, md, n;

    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_req",   32'(mem_req), 32'd0);
    chk("rst_mem_be",    32'(mem_be), 32'd0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 1, M_ACK, 1'b0);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 1, M_ACK, 1'b0);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 2, M_ACK, 1'b0);
    issue(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8011_2233, 3, M_ACK, 1'b0);
    issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, M_ACK, 1'b0);
    issue(1'b1, 3'b001, 32'h0000_0101, 32'h0000_ABCD, 32'h0, 1, M_ACK, 1'b0);
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 1, M_TMO, 1'b0);
    issue(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hDEAD_BEEF, 1, M_BOTH, 1'b0);
    issue(1'b1, 3'b100, 32'h0000_0300, 32'h5555_AAAA, 32'h0, 1, M_ACK, 1'b0);

    // reset in the middle of an access
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 1, M_RST, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req",   32'(mem_req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_req_ready", 32'(req_ready), 32'd1);

    // back-to-back: second request waits and is accepted right after the first's response
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 2, M_ACK, 1'b0);
    issue(1'b1, 3'b010, 32'h0000_0504, 32'h0BAD_F00D, 32'h0, 1, M_ACK, 1'b1);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        t  = $urandom_range(0, 4);
        f3 = (t > 2) ? 3'(t + 1) : 3'(t);
      end
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
      else if ($urandom_range(0, 1) == 0) a[0] = 1'b0;
      t  = $urandom_range(0, 15);
      md = (t == 0) ? M_TMO : (t <= 2) ? M_ERR : (t == 3) ? M_BOTH : M_ACK;
      issue(we, f3, a, $urandom, $urandom, $urandom_range(1, 4), md, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d responses and %0d bus cycles outstanding, expected 0", rq.size(), bq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
